pipeline_dbg_ctrl: RTL and testbench
====================================

# pipeline_dbg_ctrl

Parametrised run-control and host-programming unit that sits between the generic register block's software and hardware register buses and the 5-stage pipeline. It succeeds the fixed run/step/program decode used today. It adds:
- multi-instruction stepping with a programmable count
- PC breakpoints with halt and resume
- auto-incrementing instruction- and data-memory programming pointers
- a sequenced two-cycle data-memory read with captured result
- an advance-cycle counter and a packed status word.

## Interface
Parameters:
- PC_WIDTH, 9, width of the pipeline PC and of breakpoint addresses
- IMEM_AW, 9, instruction-memory address width
- DMEM_AW, 8, data-memory address width
- DMEM_DW, 64, data-memory data width
- NUM_BP, 2, number of breakpoint comparators (1..16)
- STEP_W, 16, width of the step count (≤16)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- sw_ctrl  in  32  bit0 run (level), bit1 step, bit2 pc_reset, bit3 imem_we, bit4 dmem_rd, bit5 dmem_we, bit6 bp_en (level), bit7 clear_halt, bit8 addr_load; edge bits act on 0→1
- sw_step_count  in  STEP_W  instructions per step command
- sw_imem_addr / sw_imem_wdata  in  IMEM_AW / 32  pointer load value / write data
- sw_dmem_addr / sw_dmem_wdata  in  DMEM_AW / DMEM_DW  pointer load value / write data
- sw_bp_pc  in  NUM_BP*PC_WIDTH  breakpoint i at slice i
- pc_dbg  in  PC_WIDTH  current pipeline PC
- pipe_adv  out  1  pipeline advance enable
- pipe_pc_reset  out  1  one-cycle PC reset
- imem_prog_we / imem_prog_addr / imem_prog_wdata  out  1 / IMEM_AW / 32
- dmem_prog_en / dmem_prog_we / dmem_prog_addr / dmem_prog_wdata  out  1 / 1 / DMEM_AW / DMEM_DW
- dmem_prog_rdata  in  DMEM_DW  data memory read data, valid one cycle after address
- dmem_rdata_q  out  DMEM_DW  last captured read data
- cycle_count  out  32  pipe_adv cycles
- status  out  32  see Operation

## Operation
- Edge detection:
  - sw_ctrl is registered into sw_ctrl_d.
  - pulse[k] = sw_ctrl[k] & ~sw_ctrl_d[k], combinational in edge cycle E.
- States (status[2:0]): IDLE=0, RUN=1, STEP=2, HALT=3, DRD1=4, DRD2=5.
- IDLE:
  - step pulse → STEP, remaining ← sw_step_count (0 is treated as 1).
  - Otherwise run=1 → RUN.
- RUN: run=0 → IDLE.
- STEP: remaining decrements on every pipe_adv cycle; the cycle with remaining==1 and pipe_adv → IDLE.
- Breakpoints:
  - bp_hit = bp_en & ~bp_skip & any(pc_dbg == bp[i]).
  - pipe_adv = (RUN|STEP) & ~bp_hit.
  - A hit in RUN/STEP → HALT; status[3] ← 1; status[7:4] ← lowest matching index.
- HALT:
  - Held until a clear_halt pulse → IDLE.
  - clear_halt sets bp_skip; bp_skip clears after the next pipe_adv cycle, so resume leaves the breakpoint PC.
  - clear_halt clears status[3].
- pc_reset pulse:
  - Accepted in any state.
  - pipe_pc_reset=1 in cycle E+1; state → IDLE; remaining ← 0; bp_skip, status[3] and cycle_count cleared.
- addr_load pulse loads imem_ptr ← sw_imem_addr and dmem_ptr ← sw_dmem_addr.
- imem_we pulse in IDLE/HALT:
  - imem_prog_we=1 in E+1, addr=imem_ptr, data=sw_imem_wdata.
  - imem_ptr increments, wrapping at 2^IMEM_AW.
  - In any other state the write is dropped and sticky status[8] prog_err is set.
- dmem_we pulse in IDLE/HALT:
  - dmem_prog_en=dmem_prog_we=1 for cycle E+1 at dmem_ptr.
  - dmem_ptr increments with wrap.
  - Otherwise prog_err is set.
- dmem_rd pulse in IDLE/HALT:
  - Sequence → DRD1 (en=1, we=0, addr=dmem_ptr) → DRD2 (en=1, same addr).
  - At the end of DRD2: dmem_rdata_q ← dmem_prog_rdata, dmem_ptr increments, return to the saved IDLE/HALT.
  - Edge pulses other than pc_reset arriving in DRD1/DRD2 set prog_err and are dropped.
- prog_err clears on clear_halt or pc_reset.
- status[31:16] = remaining (zero-extended).
- Priority within one cycle: pc_reset > clear_halt > dmem_rd > dmem_we > step > run.
  - imem_we coexists with step/run from IDLE; both take effect.
  - dmem_we and dmem_rd together: the read wins and prog_err is set.
- cycle_count increments on each pipe_adv cycle and saturates at 0xFFFFFFFF.

## Timing
- Reset: every output 0, all pointers 0, state IDLE, dmem_rdata_q 0, cycle_count 0, bp_skip 0.
- Reset asserted mid-operation aborts any step, halt or read immediately.
- Command latency: a transition decided in cycle E is effective from E+1.
  - The first pipe_adv after a run/step edge is E+1.
  - imem/dmem write strobes are in E+1.
  - dmem_rdata_q is valid from E+3.
- pipe_adv drops in the same cycle pc_dbg matches a breakpoint (combinational compare, no registered delay).
- pipe_pc_reset, imem_prog_we and the dmem write strobe are registered single-cycle pulses.
- A held sw_ctrl bit yields only one action; the host must write 0 before re-arming.

## Test plan
- Reset with sw_ctrl=0 → all outputs 0, status=0; run edge → pipe_adv high from E+1, cycle_count counts 1,2,3….
- sw_step_count=5, step edge → exactly 5 pipe_adv cycles, state back to IDLE, status[31:16]=0, cycle_count=5.
- bp_en=1, bp[1]=0x010, run with pc_dbg ramping → pipe_adv low at pc_dbg=0x010, status[2:0]=3, status[3]=1, status[7:4]=1; clear_halt then run → pipe_adv resumes and PC passes 0x010.
- addr_load imem=0x1FF, three imem_we edges → writes at 0x1FF, 0x000, 0x001 (wrap); imem_we edge during RUN → no strobe, status[8]=1.
- dmem_addr=0x20, dmem_we of 0x0123456789ABCDEF, addr_load again, dmem_rd with the memory model returning the data → dmem_rdata_q=0x0123456789ABCDEF at E+3, dmem_ptr=0x21.
- pc_reset edge and step edge in the same cycle during STEP → pipe_pc_reset pulse, state IDLE, no steps taken, cycle_count=0.

Source files
------------

// File: rtl/pipeline_dbg_ctrl.sv
// pipeline_dbg_ctrl: run/step/breakpoint control and host programming port for the 5-stage pipeline
module pipeline_dbg_ctrl #(
    parameter int PC_WIDTH = 9,
    parameter int IMEM_AW  = 9,
    parameter int DMEM_AW  = 8,
    parameter int DMEM_DW  = 64,
    parameter int NUM_BP   = 2,
    parameter int STEP_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                sw_ctrl,
    input  logic [STEP_W-1:0]          sw_step_count,
    input  logic [IMEM_AW-1:0]         sw_imem_addr,
    input  logic [31:0]                sw_imem_wdata,
    input  logic [DMEM_AW-1:0]         sw_dmem_addr,
    input  logic [DMEM_DW-1:0]         sw_dmem_wdata,
    input  logic [NUM_BP*PC_WIDTH-1:0] sw_bp_pc,
    input  logic [PC_WIDTH-1:0]        pc_dbg,
    output logic                       pipe_adv,
    output logic                       pipe_pc_reset,
    output logic                       imem_prog_we,
    output logic [IMEM_AW-1:0]         imem_prog_addr,
    output logic [31:0]                imem_prog_wdata,
    output logic                       dmem_prog_en,
    output logic                       dmem_prog_we,
    output logic [DMEM_AW-1:0]         dmem_prog_addr,
    output logic [DMEM_DW-1:0]         dmem_prog_wdata,
    input  logic [DMEM_DW-1:0]         dmem_prog_rdata,
    output logic [DMEM_DW-1:0]         dmem_rdata_q,
    output logic [31:0]                cycle_count,
    output logic [31:0]                status
);
    localparam int B_RUN = 0, B_STEP = 1, B_PCR = 2, B_IWE = 3, B_RD = 4, B_DWE = 5, B_BPEN = 6, B_CLR = 7, B_LD = 8;
    typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, STEP = 3'd2, HALT = 3'd3, DRD1 = 3'd4, DRD2 = 3'd5} state_t;
    state_t            state, state_n;
    logic [8:0]        ctrl_d, p;
    logic [STEP_W-1:0] remaining, rem_n;
    logic [3:0]        bp_idx, idx_n, first;
    logic [NUM_BP-1:0] match;
    logic              bp_skip, skip_n, halted, halted_n, prog_err, err_n, ret_halt, ret_n;
    logic              bp_hit, idle_halt, in_rd, iwe_n, dwe_n, drd_n, cap, ld;
    logic [IMEM_AW-1:0] imem_ptr;
    logic [DMEM_AW-1:0] dmem_ptr;
    logic              unused;

    assign p         = sw_ctrl[8:0] & ~ctrl_d;
    assign unused    = &{1'b0, sw_ctrl[31:9]};
    assign idle_halt = state == IDLE || state == HALT;
    assign in_rd     = state == DRD1 || state == DRD2;
    assign ld        = p[B_LD] & ~in_rd;
    assign bp_hit    = sw_ctrl[B_BPEN] & ~bp_skip & (|match);
    assign pipe_adv  = (state == RUN || state == STEP) & ~bp_hit;
    assign dmem_prog_en = dmem_prog_we | in_rd;
    assign status    = {16'(remaining), 7'd0, prog_err, bp_idx, halted, state};

    // Breakpoint comparators; the lowest matching index wins.
    always_comb begin
        match = '0;
        first = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            match[i] = pc_dbg == sw_bp_pc[i*PC_WIDTH +: PC_WIDTH];
            if (match[i]) first = 4'(i);
        end
    end

    // Next-state and command decode; pc_reset overrides everything, reads are uninterruptible.
    always_comb begin
        state_n  = state;
        rem_n    = remaining;
        skip_n   = bp_skip;
        halted_n = halted;
        idx_n    = bp_idx;
        err_n    = prog_err;
        ret_n    = ret_halt;
        iwe_n    = 1'b0;
        dwe_n    = 1'b0;
        drd_n    = 1'b0;
        cap      = 1'b0;
        if (p[B_PCR]) begin
            state_n  = IDLE;
            rem_n    = '0;
            skip_n   = 1'b0;
            halted_n = 1'b0;
            err_n    = 1'b0;
        end else if (in_rd) begin
            state_n = state == DRD1 ? DRD2 : (ret_halt ? HALT : IDLE);
            cap     = state == DRD2;
            err_n   = prog_err | (|p);
        end else begin
            skip_n = bp_skip & ~pipe_adv;
            iwe_n  = p[B_IWE] & idle_halt;
            err_n  = (prog_err & ~p[B_CLR]) | (p[B_IWE] & ~idle_halt)
                   | (~p[B_CLR] & (p[B_RD] | p[B_DWE]) & (~idle_halt | (p[B_RD] & p[B_DWE])));
            if (p[B_CLR]) begin
                halted_n = 1'b0;
                if (state == HALT) begin
                    state_n = IDLE;
                    skip_n  = 1'b1;
                end
            end else if (idle_halt && p[B_RD]) begin
                state_n = DRD1;
                ret_n   = state == HALT;
                drd_n   = 1'b1;
            end else if (idle_halt && p[B_DWE]) begin
                dwe_n = 1'b1;
            end else if (state == IDLE && p[B_STEP]) begin
                state_n = STEP;
                rem_n   = sw_step_count == '0 ? STEP_W'(1) : sw_step_count;
            end else if (state == IDLE && sw_ctrl[B_RUN]) begin
                state_n = RUN;
            end
            if (bp_hit && (state == RUN || state == STEP)) begin
                state_n  = HALT;
                halted_n = 1'b1;
                idx_n    = first;
            end else if (state == RUN && !sw_ctrl[B_RUN]) begin
                state_n = IDLE;
            end else if (state == STEP) begin
                rem_n = remaining - 1'b1;
                if (remaining <= STEP_W'(1)) state_n = IDLE;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            bp_skip   <= 1'b0;
            halted    <= 1'b0;
            bp_idx    <= '0;
            prog_err  <= 1'b0;
            ret_halt  <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= rem_n;
            bp_skip   <= skip_n;
            halted    <= halted_n;
            bp_idx    <= idx_n;
            prog_err  <= err_n;
            ret_halt  <= ret_n;
        end
    end

    // Edge history, programming strobes, pointers, read capture and advance counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_d          <= '0;
            pipe_pc_reset   <= 1'b0;
            imem_prog_we    <= 1'b0;
            imem_prog_addr  <= '0;
            imem_prog_wdata <= '0;
            dmem_prog_we    <= 1'b0;
            dmem_prog_addr  <= '0;
            dmem_prog_wdata <= '0;
            dmem_rdata_q    <= '0;
            imem_ptr        <= '0;
            dmem_ptr        <= '0;
            cycle_count     <= '0;
        end else begin
            ctrl_d        <= sw_ctrl[8:0];
            pipe_pc_reset <= p[B_PCR];
            imem_prog_we  <= iwe_n;
            dmem_prog_we  <= dwe_n;
            if (iwe_n) begin
                imem_prog_addr  <= imem_ptr;
                imem_prog_wdata <= sw_imem_wdata;
            end
            if (dwe_n) dmem_prog_wdata <= sw_dmem_wdata;
            if (dwe_n || drd_n) dmem_prog_addr <= dmem_ptr;
            if (cap) dmem_rdata_q <= dmem_prog_rdata;
            if (ld) imem_ptr <= sw_imem_addr;
            else if (iwe_n) imem_ptr <= imem_ptr + 1'b1;
            if (ld) dmem_ptr <= sw_dmem_addr;
            else if (dwe_n || cap) dmem_ptr <= dmem_ptr + 1'b1;
            if (p[B_PCR]) cycle_count <= '0;
            else if (pipe_adv && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_dbg_ctrl.sv
// tb_pipeline_dbg_ctrl: vector table, scoreboard and corner-case sequences for pipeline_dbg_ctrl
module tb_pipeline_dbg_ctrl;
    localparam int PC_WIDTH = 9, IMEM_AW = 9, DMEM_AW = 8, DMEM_DW = 64, NUM_BP = 2, STEP_W = 16;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic [31:0]                sw_ctrl = '0;
    logic [STEP_W-1:0]          sw_step_count = '0;
    logic [IMEM_AW-1:0]         sw_imem_addr = '0;
    logic [31:0]                sw_imem_wdata = '0;
    logic [DMEM_AW-1:0]         sw_dmem_addr = '0;
    logic [DMEM_DW-1:0]         sw_dmem_wdata = '0;
    logic [NUM_BP*PC_WIDTH-1:0] sw_bp_pc = '0;
    logic [PC_WIDTH-1:0]        pc_dbg = '0;
    logic [DMEM_DW-1:0]         dmem_prog_rdata = '0;
    logic                       pipe_adv, pipe_pc_reset, imem_prog_we, dmem_prog_en, dmem_prog_we;
    logic [IMEM_AW-1:0]         imem_prog_addr;
    logic [31:0]                imem_prog_wdata, cycle_count, status;
    logic [DMEM_AW-1:0]         dmem_prog_addr;
    logic [DMEM_DW-1:0]         dmem_prog_wdata, dmem_rdata_q;

    pipeline_dbg_ctrl #(
        .PC_WIDTH(PC_WIDTH), .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW),
        .DMEM_DW(DMEM_DW), .NUM_BP(NUM_BP), .STEP_W(STEP_W)
    ) dut (
        .clk(clk), .reset(reset), .sw_ctrl(sw_ctrl), .sw_step_count(sw_step_count),
        .sw_imem_addr(sw_imem_addr), .sw_imem_wdata(sw_imem_wdata),
        .sw_dmem_addr(sw_dmem_addr), .sw_dmem_wdata(sw_dmem_wdata),
        .sw_bp_pc(sw_bp_pc), .pc_dbg(pc_dbg), .pipe_adv(pipe_adv), .pipe_pc_reset(pipe_pc_reset),
        .imem_prog_we(imem_prog_we), .imem_prog_addr(imem_prog_addr), .imem_prog_wdata(imem_prog_wdata),
        .dmem_prog_en(dmem_prog_en), .dmem_prog_we(dmem_prog_we), .dmem_prog_addr(dmem_prog_addr),
        .dmem_prog_wdata(dmem_prog_wdata), .dmem_prog_rdata(dmem_prog_rdata),
        .dmem_rdata_q(dmem_rdata_q), .cycle_count(cycle_count), .status(status)
    );

    always #5 clk = ~clk;

    typedef struct { logic [8:0] ctrl; logic [15:0] sc; logic adv; logic pcr; logic [31:0] st; logic [31:0] cc; } vec_t;
    typedef struct { logic [IMEM_AW-1:0] addr; logic [31:0] data; } iw_t;
    typedef struct { logic [DMEM_AW-1:0] addr; logic [63:0] data; } dw_t;

    vec_t        vt [25];
    iw_t         iq [$];
    dw_t         dq [$];
    logic [63:0] rq [$];
    logic [63:0] mem [256];
    int          pass_cnt = 0, total = 0;
    bit          ramp = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock: sample DUT before the edge, update the PC and memory models after it, then score strobes.
    task automatic tick();
        logic adv, en, we, drd2;
        logic [DMEM_AW-1:0] a;
        logic [63:0] wd;
        #4;
        adv  = pipe_adv;
        en   = dmem_prog_en;
        we   = dmem_prog_we;
        a    = dmem_prog_addr;
        wd   = dmem_prog_wdata;
        drd2 = status[2:0] == 3'd5;
        @(posedge clk);
        #1;
        if (ramp && adv) pc_dbg = pc_dbg + 1'b1;
        if (en) begin
            dmem_prog_rdata = mem[a];
            if (we) mem[a] = wd;
        end
        #1;
        if (imem_prog_we) begin
            check("imem_strobe_expected", 96'(iq.size() != 0), 96'd1);
            if (iq.size() != 0) begin
                iw_t e = iq.pop_front();
                check("imem_write", {imem_prog_addr, imem_prog_wdata}, {e.addr, e.data});
            end
        end
        if (dmem_prog_we) begin
            check("dmem_strobe_expected", 96'(dq.size() != 0), 96'd1);
            if (dq.size() != 0) begin
                dw_t e = dq.pop_front();
                check("dmem_write", {dmem_prog_addr, dmem_prog_wdata}, {e.addr, e.data});
            end
        end
        if (drd2) begin
            check("read_expected", 96'(rq.size() != 0), 96'd1);
            if (rq.size() != 0) check("read_data", dmem_rdata_q, rq.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [IMEM_AW-1:0] iaddr [3];
        int k;
        iaddr = '{9'h1FF, 9'h000, 9'h001};
        foreach (mem[i]) mem[i] = '0;
        // run, pc_reset, step 5, step 0 -> 1, step+run together (step wins)
        vt[0]  = '{9'h000, 16'd5, 1'b0, 1'b0, 32'h0000_0000, 32'd0};
        vt[1]  = '{9'h001, 16'd5, 1'b0, 1'b0, 32'h0000_0000, 32'd0};
        vt[2]  = '{9'h001, 16'd5, 1'b1, 1'b0, 32'h0000_0001, 32'd0};
        vt[3]  = '{9'h001, 16'd5, 1'b1, 1'b0, 32'h0000_0001, 32'd1};
        vt[4]  = '{9'h001, 16'd5, 1'b1, 1'b0, 32'h0000_0001, 32'd2};
        vt[5]  = '{9'h000, 16'd5, 1'b1, 1'b0, 32'h0000_0001, 32'd3};
        vt[6]  = '{9'h000, 16'd5, 1'b0, 1'b0, 32'h0000_0000, 32'd4};
        vt[7]  = '{9'h004, 16'd5, 1'b0, 1'b0, 32'h0000_0000, 32'd4};
        vt[8]  = '{9'h000, 16'd5, 1'b0, 1'b1, 32'h0000_0000, 32'd0};
        vt[9]  = '{9'h002, 16'd5, 1'b0, 1'b0, 32'h0000_0000, 32'd0};
        vt[10] = '{9'h000, 16'd5, 1'b1, 1'b0, 32'h0005_0002, 32'd0};
        vt[11] = '{9'h000, 16'd5, 1'b1, 1'b0, 32'h0004_0002, 32'd1};
        vt[12] = '{9'h000, 16'd5, 1'b1, 1'b0, 32'h0003_0002, 32'd2};
        vt[13] = '{9'h000, 16'd5, 1'b1, 1'b0, 32'h0002_0002, 32'd3};
        vt[14] = '{9'h000, 16'd5, 1'b1, 1'b0, 32'h0001_0002, 32'd4};
        vt[15] = '{9'h000, 16'd5, 1'b0, 1'b0, 32'h0000_0000, 32'd5};
        vt[16] = '{9'h002, 16'd0, 1'b0, 1'b0, 32'h0000_0000, 32'd5};
        vt[17] = '{9'h002, 16'd0, 1'b1, 1'b0, 32'h0001_0002, 32'd5};
        vt[18] = '{9'h000, 16'd0, 1'b0, 1'b0, 32'h0000_0000, 32'd6};
        vt[19] = '{9'h003, 16'd2, 1'b0, 1'b0, 32'h0000_0000, 32'd6};
        vt[20] = '{9'h001, 16'd2, 1'b1, 1'b0, 32'h0002_0002, 32'd6};
        vt[21] = '{9'h001, 16'd2, 1'b1, 1'b0, 32'h0001_0002, 32'd7};
        vt[22] = '{9'h001, 16'd2, 1'b0, 1'b0, 32'h0000_0000, 32'd8};
        vt[23] = '{9'h000, 16'd2, 1'b1, 1'b0, 32'h0000_0001, 32'd8};
        vt[24] = '{9'h000, 16'd2, 1'b0, 1'b0, 32'h0000_0000, 32'd9};

        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_strobes", {pipe_adv, pipe_pc_reset, imem_prog_we, dmem_prog_en, dmem_prog_we}, 96'd0);
        check("reset_status", status, 96'd0);
        check("reset_count", cycle_count, 96'd0);
        check("reset_rdata", dmem_rdata_q, 96'd0);
        check("reset_addrs", {imem_prog_addr, dmem_prog_addr}, 96'd0);
        reset = 1'b1;
        #1;

        foreach (vt[r]) begin
            sw_ctrl = {23'd0, vt[r].ctrl};
            sw_step_count = vt[r].sc;
            #1;
            check($sformatf("vec%0d_adv", r), pipe_adv, vt[r].adv);
            check($sformatf("vec%0d_pcr", r), pipe_pc_reset, vt[r].pcr);
            check($sformatf("vec%0d_status", r), status, vt[r].st);
            check($sformatf("vec%0d_count", r), cycle_count, vt[r].cc);
            tick();
        end

        // breakpoint 1 at 0x010 with a ramping PC, then clear_halt and resume past it
        sw_bp_pc = {9'h010, 9'h100};
        pc_dbg = 9'h00C;
        ramp = 1'b1;
        sw_ctrl = 32'h41;
        for (k = 0; k < 20; k++) begin
            tick();
            if (!pipe_adv) break;
        end
        check("bp_wait_bound", 96'(k < 20), 96'd1);
        check("bp_stop_pc", pc_dbg, 96'h010);
        tick();
        check("bp_halt_status", {status[8:0], pipe_adv}, {9'h01B, 1'b0});
        sw_ctrl = 32'h40;
        tick();
        sw_ctrl = 32'hC0;
        tick();
        check("clr_halt_status", status[3:0], 96'h0);
        sw_ctrl = 32'h41;
        tick();
        check("resume_adv", {pc_dbg, pipe_adv}, {9'h010, 1'b1});
        tick();
        check("resume_pc", pc_dbg, 96'h011);
        sw_ctrl = 32'h0;
        tick();
        tick();
        ramp = 1'b0;

        // imem pointer wrap and write dropped while running
        sw_imem_addr = 9'h1FF;
        sw_ctrl = 32'h100;
        tick();
        sw_ctrl = 32'h0;
        tick();
        for (int j = 0; j < 3; j++) begin
            sw_imem_wdata = 32'hA5A5_0000 + 32'(j);
            iq.push_back('{iaddr[j], sw_imem_wdata});
            sw_ctrl = 32'h8;
            tick();
            check($sformatf("imem_strobe_e1_%0d", j), imem_prog_we, 96'd1);
            sw_ctrl = 32'h0;
            tick();
        end
        sw_ctrl = 32'h1;
        tick();
        tick();
        sw_ctrl = 32'h9;
        tick();
        check("imem_drop_in_run", imem_prog_we, 96'd0);
        check("prog_err_set", status[8], 96'd1);
        sw_ctrl = 32'h0;
        tick();
        tick();
        sw_ctrl = 32'h80;
        tick();
        sw_ctrl = 32'h0;
        tick();
        check("prog_err_clr", status[8], 96'd0);

        // dmem write, reload pointer, sequenced read
        sw_dmem_addr = 8'h20;
        sw_ctrl = 32'h100;
        tick();
        sw_ctrl = 32'h0;
        tick();
        sw_dmem_wdata = 64'h0123_4567_89AB_CDEF;
        dq.push_back('{8'h20, sw_dmem_wdata});
        sw_ctrl = 32'h20;
        tick();
        check("dmem_we_e1", {dmem_prog_en, dmem_prog_we}, 96'b11);
        sw_ctrl = 32'h0;
        tick();
        sw_ctrl = 32'h100;
        tick();
        sw_ctrl = 32'h0;
        tick();
        rq.push_back(64'h0123_4567_89AB_CDEF);
        sw_ctrl = 32'h10;
        tick();
        check("drd1", {status[2:0], dmem_prog_en, dmem_prog_we, dmem_prog_addr}, {3'd4, 1'b1, 1'b0, 8'h20});
        sw_ctrl = 32'h0;
        tick();
        check("drd2", {status[2:0], dmem_prog_en, dmem_prog_addr}, {3'd5, 1'b1, 8'h20});
        tick();
        check("rdata_e3", dmem_rdata_q, 96'h0123_4567_89AB_CDEF);
        check("drd_return", status[2:0], 96'd0);
        sw_dmem_wdata = 64'hFEDC_BA98_7654_3210;
        dq.push_back('{8'h21, sw_dmem_wdata});
        sw_ctrl = 32'h20;
        tick();
        sw_ctrl = 32'h0;
        tick();
        // read and write together: read wins, error flagged
        rq.push_back(64'h0);
        sw_ctrl = 32'h30;
        tick();
        check("rd_we_both", {status[8], status[2:0], dmem_prog_we}, {1'b1, 3'd4, 1'b0});
        sw_ctrl = 32'h0;
        tick();
        tick();
        sw_ctrl = 32'h80;
        tick();
        sw_ctrl = 32'h0;
        tick();

        // pc_reset together with step while stepping
        sw_step_count = 16'd10;
        sw_ctrl = 32'h2;
        tick();
        sw_ctrl = 32'h0;
        tick();
        tick();
        check("step_active", status[2:0], 96'd2);
        sw_ctrl = 32'h6;
        tick();
        check("pcr_pulse", pipe_pc_reset, 96'd1);
        check("pcr_idle", {status[31:16], status[3:0], pipe_adv}, 96'd0);
        check("pcr_count", cycle_count, 96'd0);
        tick();
        check("pcr_single", {pipe_pc_reset, pipe_adv, status[2:0]}, 96'd0);
        check("pcr_no_steps", cycle_count, 96'd0);

        // asynchronous reset in the middle of a run
        sw_ctrl = 32'h1;
        tick();
        tick();
        check("run_before_reset", pipe_adv, 96'd1);
        reset = 1'b0;
        #1;
        check("async_reset", {pipe_adv, status, cycle_count}, 96'd0);
        sw_ctrl = 32'h0;
        reset = 1'b1;
        tick();

        check("imem_queue_drained", 96'(iq.size()), 96'd0);
        check("dmem_queue_drained", 96'(dq.size()), 96'd0);
        check("read_queue_drained", 96'(rq.size()), 96'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
